// File: rtl/i2c_regs_pkg.sv
// i2c_regs_pkg
//   Shared definitions for the I2C register endpoint: register addresses,
//   fixed identification values and the protocol FSM state encoding.
package i2c_regs_pkg;

  localparam logic [7:0] ADDR_DEVICE_ID   = 8'h00;
  localparam logic [7:0] ADDR_VERSION_MAJ = 8'h01;
  localparam logic [7:0] ADDR_VERSION_MIN = 8'h02;
  localparam logic [7:0] ADDR_SCRATCH0    = 8'h05;
  localparam logic [7:0] ADDR_SCRATCH1    = 8'h06;
  localparam logic [7:0] ADDR_LINK_CAPS   = 8'h10;
  localparam logic [7:0] ADDR_LED_OUT     = 8'h20;
  localparam logic [7:0] ADDR_SW_IN       = 8'h22;
  localparam logic [7:0] ADDR_SPI_STAT    = 8'h24;
  localparam logic [7:0] ADDR_SPI_RX      = 8'h25;

  localparam logic [7:0] DEVICE_ID_VAL    = 8'hA7;
  localparam logic [7:0] VERSION_MAJ_VAL  = 8'h01;
  localparam logic [7:0] VERSION_MIN_VAL  = 8'h00;
  localparam logic [7:0] LINK_CAPS_VAL    = 8'b00_01_0_1_0_1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_reg_file.sv
// i2c_reg_file
//   8-bit register map behind the I2C protocol engine.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     reg_addr          register address (current pointer)
//     reg_wdata/reg_wr  write data and 1-clk write strobe
//     reg_rd            1-clk read strobe (map has no read side effects)
//     reg_rdata         combinational read data for reg_addr
//     sw_sync           already-synchronized switch inputs
//     spi_active        SPI link status
//     spi_rx_byte       last SPI received byte
//     led_out           LED drive (LED_OUT register)
module i2c_reg_file
  import i2c_regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_wr,
  input  logic       reg_rd,
  output logic [7:0] reg_rdata,
  input  logic [7:0] sw_sync,
  input  logic       spi_active,
  input  logic [7:0] spi_rx_byte,
  output logic [7:0] led_out
);

  logic [7:0] scratch0_q, scratch0_d;
  logic [7:0] scratch1_q, scratch1_d;
  logic [7:0] led_q, led_d;
  logic       unused_rd;

  // No register in this map clears or changes on read.
  assign unused_rd = reg_rd;

  always_comb begin
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    led_d      = led_q;
    // Writes to read-only or unmapped addresses fall through and are dropped.
    if (reg_wr) begin
      case (reg_addr)
        ADDR_SCRATCH0: scratch0_d = reg_wdata;
        ADDR_SCRATCH1: scratch1_d = reg_wdata;
        ADDR_LED_OUT:  led_d      = reg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch0_q <= 8'h00;
      scratch1_q <= 8'h00;
      led_q      <= 8'h00;
    end else begin
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      led_q      <= led_d;
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      ADDR_DEVICE_ID:   reg_rdata = DEVICE_ID_VAL;
      ADDR_VERSION_MAJ: reg_rdata = VERSION_MAJ_VAL;
      ADDR_VERSION_MIN: reg_rdata = VERSION_MIN_VAL;
      ADDR_SCRATCH0:    reg_rdata = scratch0_q;
      ADDR_SCRATCH1:    reg_rdata = scratch1_q;
      ADDR_LINK_CAPS:   reg_rdata = LINK_CAPS_VAL;
      ADDR_LED_OUT:     reg_rdata = led_q;
      ADDR_SW_IN:       reg_rdata = sw_sync;
      ADDR_SPI_STAT:    reg_rdata = {7'b0, spi_active};
      ADDR_SPI_RX:      reg_rdata = spi_rx_byte;
      default:          reg_rdata = 8'h00;
    endcase
  end

  assign led_out = led_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs
//   I2C target endpoint: input synchronizers, bit-level protocol FSM and the
//   register file that drives LEDs and reports switches / SPI status.
//   Ports:
//     clk, rst_n        system clock, asynchronous active-low reset
//     scl_i, sda_i      I2C pad inputs (asynchronous)
//     sda_o, sda_oe     open-drain SDA drive (sda_o fixed low)
//     led_out           LED drive
//     sw_in             board switches (asynchronous)
//     spi_active        SPI link status
//     spi_rx_byte       last SPI received byte
module i2c_slave_regs
  import i2c_regs_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic [7:0] led_out,
  input  logic [7:0] sw_in,
  input  logic       spi_active,
  input  logic [7:0] spi_rx_byte
);

  // Synchronizers plus one extra stage on SCL/SDA for edge detection.
  // Bus lines reset high (idle bus) so reset release creates no false edge.
  logic       scl_meta_q, scl_q, scl_prev_q;
  logic       sda_meta_q, sda_q, sda_prev_q;
  logic [7:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_q      <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_q      <= 1'b1;
      sda_prev_q <= 1'b1;
      sw_meta_q  <= 8'h00;
      sw_sync_q  <= 8'h00;
    end else begin
      scl_meta_q <= scl_i;
      scl_q      <= scl_meta_q;
      scl_prev_q <= scl_q;
      sda_meta_q <= sda_i;
      sda_q      <= sda_meta_q;
      sda_prev_q <= sda_q;
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
    end
  end

  logic       scl_rise, scl_fall, bus_start, bus_stop;
  logic [7:0] rx_byte;

  logic [7:0] shift_q;

  assign scl_rise  = scl_q & ~scl_prev_q;
  assign scl_fall  = ~scl_q & scl_prev_q;
  assign bus_start = scl_q & scl_prev_q & sda_prev_q & ~sda_q;
  assign bus_stop  = scl_q & scl_prev_q & ~sda_prev_q & sda_q;
  // Byte as it will look once the bit on this SCL rise is shifted in.
  assign rx_byte   = {shift_q[6:0], sda_q};

  i2c_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] ptr_q;
  logic       rw_q;
  logic       sda_oe_q;
  logic       load_pending_q;
  logic       reg_wr_q;
  logic       reg_rd_q;
  logic [7:0] reg_wdata_q;
  logic [7:0] reg_rdata;

  // In the ACK states sda_oe_q doubles as the phase flag: the first SCL fall
  // starts driving the ACK, the second one ends it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'h00;
      ptr_q          <= 8'h00;
      rw_q           <= 1'b0;
      sda_oe_q       <= 1'b0;
      load_pending_q <= 1'b0;
      reg_wr_q       <= 1'b0;
      reg_rd_q       <= 1'b0;
      reg_wdata_q    <= 8'h00;
    end else begin
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      if (bus_stop) begin
        state_q        <= ST_IDLE;
        sda_oe_q       <= 1'b0;
        load_pending_q <= 1'b0;
      end else if (bus_start) begin
        state_q        <= ST_ADDR;
        bit_cnt_q      <= 3'd0;
        load_pending_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_q <= ST_ADDR_ACK;
                rw_q    <= rx_byte[0];
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else if (rw_q) begin
              // End of address ACK on a read: fetch and present bit 7 at once.
              state_q   <= ST_RDATA;
              shift_q   <= reg_rdata;
              sda_oe_q  <= ~reg_rdata[7];
              reg_rd_q  <= 1'b1;
              bit_cnt_q <= 3'd0;
            end else begin
              state_q   <= ST_PTR;
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 3'd0;
            end
          end
          ST_PTR: if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_q   <= rx_byte;
              state_q <= ST_PTR_ACK;
            end
          end
          ST_PTR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q  <= 1'b0;
              state_q   <= ST_WDATA;
              bit_cnt_q <= 3'd0;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shift_q   <= rx_byte;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              reg_wr_q    <= 1'b1;
              reg_wdata_q <= rx_byte;
              state_q     <= ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              // Pointer advances only after the write strobe has used it.
              sda_oe_q  <= 1'b0;
              ptr_q     <= ptr_q + 8'd1;
              state_q   <= ST_WDATA;
              bit_cnt_q <= 3'd0;
            end
          end
          ST_RDATA: begin
            if (scl_fall) begin
              if (load_pending_q) begin
                shift_q        <= reg_rdata;
                sda_oe_q       <= ~reg_rdata[7];
                reg_rd_q       <= 1'b1;
                load_pending_q <= 1'b0;
                bit_cnt_q      <= 3'd0;
              end else begin
                shift_q  <= shift_q << 1;
                sda_oe_q <= ~shift_q[6];
              end
            end else if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= ST_RDATA_ACK;
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
            end else if (scl_rise) begin
              if (!sda_q) begin
                ptr_q          <= ptr_q + 8'd1;
                state_q        <= ST_RDATA;
                load_pending_q <= 1'b1;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  i2c_reg_file u_reg_file (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_addr    (ptr_q),
    .reg_wdata   (reg_wdata_q),
    .reg_wr      (reg_wr_q),
    .reg_rd      (reg_rd_q),
    .reg_rdata   (reg_rdata),
    .sw_sync     (sw_sync_q),
    .spi_active  (spi_active),
    .spi_rx_byte (spi_rx_byte),
    .led_out     (led_out)
  );

  assign sda_o  = 1'b0;
  assign sda_oe = sda_oe_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs
//   Bit-banged I2C master driving i2c_slave_regs, with a register-map model
//   that predicts read data, LED state and the register pointer.
module tb_i2c_slave_regs;

  localparam int Q = 60;  // quarter SCL period in ns

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       scl_i = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_o, sda_oe;
  logic [7:0] led_out;
  logic [7:0] sw_in = 8'h00;
  logic       spi_active = 1'b0;
  logic [7:0] spi_rx_byte = 8'h00;
  logic       sda_bus;

  assign sda_bus = sda_m & (sda_oe ? sda_o : 1'b1);

  always #5 clk = ~clk;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (scl_i),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .sda_oe      (sda_oe),
    .led_out     (led_out),
    .sw_in       (sw_in),
    .spi_active  (spi_active),
    .spi_rx_byte (spi_rx_byte)
  );

  int checks = 0;
  int errors = 0;

  // sda_oe must never change while SCL is high (outside reset).
  logic oe_prev;
  int   oe_glitches = 0;
  always @(posedge clk) begin
    if (rst_n && scl_i && (sda_oe !== oe_prev)) oe_glitches <= oe_glitches + 1;
    oe_prev <= sda_oe;
  end

  // ---------------- reference model ----------------
  logic [7:0] m_s0 = 8'h00, m_s1 = 8'h00, m_led = 8'h00, m_ptr = 8'h00;

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    case (a)
      8'h00: return 8'hA7;
      8'h01: return 8'h01;
      8'h02: return 8'h00;
      8'h05: return m_s0;
      8'h06: return m_s1;
      8'h10: return 8'h15;
      8'h20: return m_led;
      8'h22: return sw_in;
      8'h24: return {7'b0, spi_active};
      8'h25: return spi_rx_byte;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
    case (a)
      8'h05: m_s0 = d;
      8'h06: m_s1 = d;
      8'h20: m_led = d;
      default: ;
    endcase
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  // ---------------- bit-level master ----------------
  task automatic m_start();
    sda_m = 1'b1; scl_i = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_i = 1'b0; #Q;
  endtask

  task automatic m_rstart();
    sda_m = 1'b1; #Q;
    scl_i = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_i = 1'b0; #Q;
  endtask

  task automatic m_stop();
    sda_m = 1'b0; #Q;
    scl_i = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic m_wbit(input logic b);
    sda_m = b; #Q;
    scl_i = 1'b1; #(2*Q);
    scl_i = 1'b0; #Q;
  endtask

  task automatic m_rbit(output logic b);
    sda_m = 1'b1; #Q;
    scl_i = 1'b1; #Q;
    b = sda_bus; #Q;
    scl_i = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) m_wbit(b[i]);
    m_rbit(bit_v);
    ack = ~bit_v;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(bit_v);
      d[i] = bit_v;
    end
    m_wbit(~mack);
  endtask

  // ---------------- transactions ----------------
  logic [7:0] wbuf[4];
  logic [7:0] rbuf[4];

  task automatic wr_txn(input logic [7:0] a, input int n);
    logic ack;
    m_start();
    write_byte(8'hA0, ack); check8("w_addr_ack", {7'b0, ack}, 8'h01);
    write_byte(a, ack);     check8("w_ptr_ack", {7'b0, ack}, 8'h01);
    m_ptr = a;
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      check8("w_data_ack", {7'b0, ack}, 8'h01);
      model_wr(m_ptr, wbuf[i]);
      m_ptr++;
      check8("led_after_ack", led_out, m_led);
    end
    m_stop();
    $display("WR ptr=%02h n=%0d d0=%02h d1=%02h led=%02h", a, n, wbuf[0], wbuf[1], led_out);
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [7:0] a, input int n);
    logic ack;
    logic [7:0] d, exp;
    m_start();
    if (set_ptr) begin
      write_byte(8'hA0, ack); check8("r_waddr_ack", {7'b0, ack}, 8'h01);
      write_byte(a, ack);     check8("r_ptr_ack", {7'b0, ack}, 8'h01);
      m_ptr = a;
      m_rstart();
    end
    write_byte(8'hA1, ack); check8("r_raddr_ack", {7'b0, ack}, 8'h01);
    for (int i = 0; i < n; i++) begin
      exp = model_rd(m_ptr);
      read_byte(i < n - 1, d);
      check8("rd_data", d, exp);
      rbuf[i] = d;
      if (i < n - 1) m_ptr++;
    end
    m_stop();
    $display("RD ptr=%02h set=%0d n=%0d d0=%02h", set_ptr ? a : 8'hxx, set_ptr, n, rbuf[0]);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[13];
  logic [7:0] alist[12];

  initial begin
    logic ack;
    logic [7:0] d;
    int op, n;
    logic [7:0] a;

    tbl[0]  = '{1'b0, 8'h00, 8'h00, 8'hA7};
    tbl[1]  = '{1'b0, 8'h01, 8'h00, 8'h01};
    tbl[2]  = '{1'b0, 8'h02, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'h10, 8'h00, 8'h15};
    tbl[4]  = '{1'b1, 8'h05, 8'h55, 8'h55};
    tbl[5]  = '{1'b0, 8'h05, 8'h00, 8'h55};
    tbl[6]  = '{1'b1, 8'h05, 8'hAA, 8'hAA};
    tbl[7]  = '{1'b0, 8'h05, 8'h00, 8'hAA};
    tbl[8]  = '{1'b1, 8'h06, 8'h12, 8'h12};
    tbl[9]  = '{1'b0, 8'h06, 8'h00, 8'h12};
    tbl[10] = '{1'b0, 8'h05, 8'h00, 8'hAA};
    tbl[11] = '{1'b1, 8'h20, 8'hF0, 8'hF0};
    tbl[12] = '{1'b0, 8'h20, 8'h00, 8'hF0};

    alist = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h06, 8'h10,
              8'h20, 8'h22, 8'h24, 8'h25, 8'h07, 8'hFF};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check8("rst_sda_oe", {7'b0, sda_oe}, 8'h00);
    check8("rst_sda_o", {7'b0, sda_o}, 8'h00);
    check8("rst_led", led_out, 8'h00);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].is_wr) begin
        wbuf[0] = tbl[i].data;
        wr_txn(tbl[i].addr, 1);
        if (tbl[i].addr == 8'h20) check8("tbl_led", led_out, tbl[i].exp);
      end else begin
        rd_txn(1'b1, tbl[i].addr, 1);
        check8("tbl_read", rbuf[0], tbl[i].exp);
      end
    end

    // Switch sampling
    sw_in = 8'h3C;
    #100;
    rd_txn(1'b1, 8'h22, 1);
    check8("sw_in_read", rbuf[0], 8'h3C);

    // SPI status burst
    spi_active = 1'b1; spi_rx_byte = 8'h5A;
    rd_txn(1'b1, 8'h24, 2);
    check8("spi_stat", rbuf[0], 8'h01);
    check8("spi_rx", rbuf[1], 8'h5A);

    // Wrong address: no ACK, following bytes ignored until STOP
    m_start();
    write_byte(8'hA2, ack); check8("nack_addr", {7'b0, ack}, 8'h00);
    write_byte(8'h05, ack); check8("ignored_ptr", {7'b0, ack}, 8'h00);
    write_byte(8'h99, ack); check8("ignored_data", {7'b0, ack}, 8'h00);
    m_stop();
    $display("WR addr=51 ignored");
    rd_txn(1'b1, 8'h05, 1);
    check8("after_nack_s0", rbuf[0], 8'hAA);

    // Burst write and burst read
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    wr_txn(8'h05, 2);
    rd_txn(1'b1, 8'h05, 2);
    check8("burst_rd0", rbuf[0], 8'h11);
    check8("burst_rd1", rbuf[1], 8'h22);

    // Reset asserted while the slave drives a read bit
    m_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    m_rstart();
    write_byte(8'hA1, ack);
    check8("mid_read_oe_on", {7'b0, sda_oe}, 8'h01);
    rst_n = 1'b0;
    #1;
    check8("mid_read_oe_rel", {7'b0, sda_oe}, 8'h00);
    check8("mid_read_led_rst", led_out, 8'h00);
    $display("RST during read oe=%0b", sda_oe);
    m_s0 = 8'h00; m_s1 = 8'h00; m_led = 8'h00; m_ptr = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_stop();
    rd_txn(1'b0, 8'h00, 1);
    check8("ptr_after_rst", rbuf[0], 8'hA7);
    rd_txn(1'b1, 8'h05, 1);
    check8("s0_after_rst", rbuf[0], 8'h00);

    // Randomized traffic against the model
    for (int it = 0; it < 20; it++) begin
      op = $urandom_range(0, 2);
      a  = alist[$urandom_range(0, 11)];
      if (op == 0) begin
        n = $urandom_range(1, 2);
        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        wr_txn(a, n);
      end else if (op == 1) begin
        sw_in = 8'($urandom);
        spi_active = 1'($urandom);
        spi_rx_byte = 8'($urandom);
        #100;
        rd_txn(1'b1, a, $urandom_range(1, 3));
      end else begin
        rd_txn(1'b0, 8'h00, $urandom_range(1, 2));
      end
    end

    checks++;
    if (oe_glitches != 0) begin
      errors++;
      $display("FAIL oe_stable_scl_high actual=%0d expected=0", oe_glitches);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
